room_thermal_model: RTL and testbench

- Behavioural plant model of the room/HVAC loop, running in synthesizable RTL.
- Consumes the thermostat's heating/cooling commands and produces the 8-bit indoor_temp that the thermostat reads, so the control loop can be closed in simulation and on FPGA.
- Models actuator dead time, heat/cool rate, leakage toward outdoor temperature, and a conflicting-command fault.

---
 rtl/thermo_pkg.sv | 32 +++
 rtl/room_thermal_model_if.sv | 27 ++
 rtl/thermo_tick_prescaler.sv | 32 +++
 rtl/room_thermal_model.sv | 174 +++++++++++++++++
 tb/tb_room_thermal_model.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/thermo_pkg.sv
// Shared types and helpers for the room thermal plant model.
// State encoding, temperature widths and saturating arithmetic.
package thermo_pkg;

  localparam int TEMP_W = 8;
  localparam int SUM_W  = 10;

  typedef logic [TEMP_W-1:0]       temp_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_HEAT_RAMP,
    ST_HEAT_FULL,
    ST_COOL_RAMP,
    ST_COOL_FULL,
    ST_FAULT
  } act_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic temp_t sat_add(temp_t base, sum_t inc);
    sum_t s;
    s = sum_t'({2'b00, base}) + inc;
    if (s < 0)
      return '0;
    if (s > sum_t'(2**TEMP_W - 1))
      return '1;
    return s[TEMP_W-1:0];
  endfunction

endpackage

// File: rtl/room_thermal_model_if.sv
// Thermostat <-> plant bundle: commands in, temperature out.
// master = thermostat side, slave = plant model.
interface room_thermal_model_if;
  import thermo_pkg::*;

  logic  heating;
  logic  cooling;
  temp_t outdoor_temp;
  logic  init_load;
  temp_t init_temp;
  temp_t indoor_temp;
  logic  temp_valid;
  logic  fault;

  modport master (
    output heating, cooling, outdoor_temp,
    output init_load, init_temp,
    input  indoor_temp, temp_valid, fault
  );

  modport slave (
    input  heating, cooling, outdoor_temp,
    input  init_load, init_temp,
    output indoor_temp, temp_valid, fault
  );

endinterface

// File: rtl/thermo_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter with a one-cycle tick strobe.
// clr_i restarts the period so the next tick is a full TICK_DIV away.
module thermo_tick_prescaler #(
  parameter int TICK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o)
      cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/room_thermal_model.sv
// Room/HVAC plant: actuator dead-time FSM, heat/cool rate, leakage.
// Define THERMAL_NOISE_EN to add LFSR-driven +/-1 noise per tick.
module room_thermal_model
  import thermo_pkg::*;
#(
  parameter int TICK_DIV   = 16,
  parameter int RAMP_TICKS = 4,
  parameter int HEAT_RATE  = 1,
  parameter int COOL_RATE  = 1,
  parameter int LEAK_DIV   = 4,
  parameter int INIT_TEMP  = 25
) (
  input  logic clk,
  input  logic reset,
  room_thermal_model_if.slave bus
);

  localparam int RW = $clog2(RAMP_TICKS + 1);
  localparam int LW = $clog2(LEAK_DIV + 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_TICKS - 1);
  localparam logic [LW-1:0] LEAK_LAST = LW'(LEAK_DIV - 1);

  logic          tick, upd, h, c, leak_wrap;
  act_state_t    state_q, state_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [LW-1:0] leak_q, leak_d;
  temp_t         temp_q, temp_d;
  logic          valid_q, fault_q;
  sum_t          act, lk, nz;

  assign h   = bus.heating;
  assign c   = bus.cooling;
  assign upd = tick && !bus.init_load;

  thermo_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (bus.init_load),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    ramp_d  = ramp_q;
    if (h && c) begin
      state_d = ST_FAULT;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (h) begin
            state_d = ST_HEAT_RAMP;
            ramp_d  = '0;
          end else if (c) begin
            state_d = ST_COOL_RAMP;
            ramp_d  = '0;
          end
        end
        ST_HEAT_RAMP, ST_HEAT_FULL: begin
          if (!h) begin
            state_d = c ? ST_COOL_RAMP : ST_OFF;
            ramp_d  = c ? '0 : ramp_q;
          end else if (state_q == ST_HEAT_RAMP) begin
            if (ramp_q == RAMP_LAST)
              state_d = ST_HEAT_FULL;
            else
              ramp_d = ramp_q + RW'(1);
          end
        end
        ST_COOL_RAMP, ST_COOL_FULL: begin
          if (!c) begin
            state_d = h ? ST_HEAT_RAMP : ST_OFF;
            ramp_d  = h ? '0 : ramp_q;
          end else if (state_q == ST_COOL_RAMP) begin
            if (ramp_q == RAMP_LAST)
              state_d = ST_COOL_FULL;
            else
              ramp_d = ramp_q + RW'(1);
          end
        end
        ST_FAULT: begin
          if (!h && !c)
            state_d = ST_OFF;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Actuator effect uses the state held before this tick's transition.
  always_comb begin
    act = '0;
    unique case (1'b1)
      (state_q == ST_HEAT_FULL): act = sum_t'(HEAT_RATE);
      (state_q == ST_COOL_FULL): act = -sum_t'(COOL_RATE);
      default: act = '0;
    endcase
    leak_wrap = (leak_q == LEAK_LAST);
    leak_d    = leak_wrap ? '0 : leak_q + LW'(1);
    lk        = '0;
    if (leak_wrap) begin
      if (temp_q < bus.outdoor_temp)
        lk = sum_t'(1);
      else if (temp_q > bus.outdoor_temp)
        lk = -sum_t'(1);
    end
    temp_d = sat_add(temp_q, act + lk + nz);
  end

`ifdef THERMAL_NOISE_EN
  logic [7:0] lfsr_q;
  logic       fb;

  assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    nz = '0;
    unique case (lfsr_q[1:0])
      2'b11:   nz = sum_t'(1);
      2'b00:   nz = -sum_t'(1);
      default: nz = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr_q <= LFSR_SEED;
    else if (bus.init_load)
      lfsr_q <= LFSR_SEED;
    else if (tick)
      lfsr_q <= {lfsr_q[6:0], fb};
  end
`else
  assign nz = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
      ramp_q  <= '0;
    end else if (bus.init_load) begin
      state_q <= ST_OFF;
      ramp_q  <= '0;
    end else if (upd) begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      temp_q  <= temp_t'(INIT_TEMP);
      leak_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (bus.init_load) begin
      temp_q  <= bus.init_temp;
      leak_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (upd) begin
      temp_q  <= temp_d;
      leak_q  <= leak_d;
      valid_q <= 1'b1;
      fault_q <= (state_d == ST_FAULT);
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.indoor_temp = temp_q;
  assign bus.temp_valid  = valid_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_room_thermal_model.sv
// Directed bench for room_thermal_model at TICK_DIV=4, RAMP_TICKS=2.
// Expected temperatures are hand-derived tick by tick.
module tb_room_thermal_model;
  import thermo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  room_thermal_model_if bus();

  room_thermal_model #(
    .TICK_DIV   (4),
    .RAMP_TICKS (2),
    .HEAT_RATE  (1),
    .COOL_RATE  (1),
    .LEAK_DIV   (4),
    .INIT_TEMP  (25)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic next_tick(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.temp_valid && n < 16);
    check("tick_seen", 32'(bus.temp_valid), 1);
  endtask

  task automatic load(input int t, input int od,
                      input logic hh, input logic cc);
    bus.init_load    = 1'b1;
    bus.init_temp    = temp_t'(t);
    bus.outdoor_temp = temp_t'(od);
    bus.heating      = hh;
    bus.cooling      = cc;
    @(posedge clk);
    #1;
    bus.init_load = 1'b0;
  endtask

  int heat_exp[8]  = '{25, 25, 25, 26, 27, 28, 29, 29};
  int fault_exp[4] = '{30, 30, 30, 29};
  int sw_exp[12]   = '{50, 50, 50, 51, 52, 53,
                       53, 52, 51, 50, 49, 49};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    reset            = 1'b1;
    bus.heating      = 1'b0;
    bus.cooling      = 1'b0;
    bus.init_load    = 1'b0;
    bus.init_temp    = '0;
    bus.outdoor_temp = 8'd25;
    #12;
    @(negedge clk);
    reset = 1'b0;
    check("rst_temp", 32'(bus.indoor_temp), 25);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_valid", 32'(bus.temp_valid), 0);

    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("valid_e%0d", e),
            32'(bus.temp_valid), 32'(e % 4 == 0));
    end
    check("idle_temp", 32'(bus.indoor_temp), 25);

    @(negedge clk);
    reset       = 1'b1;
    bus.heating = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      next_tick(n);
      check($sformatf("heat_gap%0d", k), n, 4);
      check($sformatf("heat_t%0d", k + 1),
            32'(bus.indoor_temp), heat_exp[k]);
    end

    repeat (3) @(posedge clk);
    #1;
    load(0, 0, 1'b0, 1'b1);
    check("load_novalid", 32'(bus.temp_valid), 0);
    check("load_temp", 32'(bus.indoor_temp), 0);
    for (int k = 0; k < 20; k++) begin
      next_tick(n);
      if (k == 0)
        check("load_gap", n, 4);
      check($sformatf("sat_lo_t%0d", k + 1),
            32'(bus.indoor_temp), 0);
    end

    load(255, 255, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      next_tick(n);
      check($sformatf("sat_hi_t%0d", k + 1),
            32'(bus.indoor_temp), 255);
    end

    load(30, 25, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      next_tick(n);
      check($sformatf("flt_on_t%0d", k + 1),
            32'(bus.fault), 1);
      check($sformatf("flt_temp_t%0d", k + 1),
            32'(bus.indoor_temp), fault_exp[k]);
    end
    bus.heating = 1'b0;
    bus.cooling = 1'b0;
    next_tick(n);
    check("flt_off", 32'(bus.fault), 0);
    check("flt_off_temp", 32'(bus.indoor_temp), 29);

    load(50, 50, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      next_tick(n);
      check($sformatf("sw_t%0d", k + 1),
            32'(bus.indoor_temp), sw_exp[k]);
      if (k == 4) begin
        bus.heating = 1'b0;
        bus.cooling = 1'b1;
      end
    end

    load(40, 40, 1'b1, 1'b0);
    next_tick(n);
    next_tick(n);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_temp", 32'(bus.indoor_temp), 25);
    check("mid_rst_valid", 32'(bus.temp_valid), 0);
    check("mid_rst_fault", 32'(bus.fault), 0);
    @(negedge clk);
    reset = 1'b0;
    next_tick(n);
    check("post_rst_gap", n, 4);
    check("post_rst_temp", 32'(bus.indoor_temp), 25);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
